// File: rtl/fifo_128x8_pkg.sv
// fifo_128x8_pkg
//   Shared sizes for the 128x8 FWFT FIFO controller and its block RAM.
//   AW        : RAM address width
//   DW        : data width
//   RAM_DEPTH : entries held in the RAM
//   LEVEL_MAX : total capacity (RAM entries plus the RAM read register)
//   LEVEL_W   : width of occupancy counters (holds 0..LEVEL_MAX)
package fifo_128x8_pkg;

  localparam int AW        = 7;
  localparam int DW        = 8;
  localparam int RAM_DEPTH = 128;
  localparam int LEVEL_MAX = 129;
  localparam int LEVEL_W   = 8;

  typedef logic [AW-1:0]      addr_t;
  typedef logic [DW-1:0]      data_t;
  typedef logic [LEVEL_W-1:0] level_t;

endpackage

// File: rtl/dpram_128x8.sv
// dpram_128x8
//   Simple dual-port 128x8 block RAM, one write port and one registered
//   read port, both on the same clock. Contents and the read register are
//   not reset.
//   clk      : clock for both ports
//   wen      : write enable
//   waddr    : write address
//   data_in  : write data
//   ren      : read enable, loads data_out on the next edge
//   raddr    : read address
//   data_out : registered read data
module dpram_128x8
  import fifo_128x8_pkg::*;
(
  input  logic  clk,
  input  logic  wen,
  input  addr_t waddr,
  input  data_t data_in,
  input  logic  ren,
  input  addr_t raddr,
  output data_t data_out
);

  data_t mem [0:RAM_DEPTH-1];

  always_ff @(posedge clk) begin
    if (wen) begin
      mem[waddr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (ren) begin
      data_out <= mem[raddr];
    end
  end

endmodule

// File: rtl/fifo_128x8_ctrl.sv
// fifo_128x8_ctrl
//   First-word-fall-through FIFO controller sequencing one dpram_128x8.
//   The RAM read register doubles as the FIFO output register, so total
//   capacity is 128 RAM entries plus one held at the output (129).
//   clk          : clock
//   RN           : asynchronous active-low reset
//   flush        : synchronous clear of pointers, counts and out_valid
//   in_valid     : producer has data
//   in_data      : push data
//   in_ready     : push accepted this cycle when in_valid is high
//   out_valid    : out_data holds the head entry
//   out_data     : head entry (RAM read register)
//   out_ready    : consumer takes the head this cycle
//   level        : entries held, 0..129
//   full/empty   : level==129 / level==0
//   almost_full  : level >= AFULL_TH
//   almost_empty : level <= AEMPTY_TH
module fifo_128x8_ctrl
  import fifo_128x8_pkg::*;
#(
  parameter int AFULL_TH  = 120,
  parameter int AEMPTY_TH = 8
) (
  input  logic       clk,
  input  logic       RN,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic [7:0] level,
  output logic       full,
  output logic       empty,
  output logic       almost_full,
  output logic       almost_empty
);

  addr_t  wptr_reg, wptr_next;
  addr_t  rptr_reg, rptr_next;
  level_t ram_cnt_reg, ram_cnt_next;
  logic   out_valid_reg, out_valid_next;
  level_t level_reg, level_next;
  logic   run_reg;
  logic   full_reg, empty_reg, afull_reg, aempty_reg;

  logic   push, pop, fetch;

  // run_reg keeps in_ready low until the first edge after reset release.
  assign in_ready = run_reg & ~flush & (ram_cnt_reg != level_t'(RAM_DEPTH));

  always_comb begin
    push           = in_valid & in_ready;
    pop            = out_valid_reg & out_ready;
    // Refill the output register whenever it is empty or being drained.
    fetch          = (ram_cnt_reg != '0) & (~out_valid_reg | pop) & ~flush;

    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    ram_cnt_next   = ram_cnt_reg;
    out_valid_next = out_valid_reg;

    if (flush) begin
      wptr_next      = '0;
      rptr_next      = '0;
      ram_cnt_next   = '0;
      out_valid_next = 1'b0;
    end else begin
      if (push) begin
        wptr_next = wptr_reg + 1'b1;
      end
      if (fetch) begin
        rptr_next = rptr_reg + 1'b1;
      end
      ram_cnt_next = ram_cnt_reg + level_t'(push) - level_t'(fetch);
      if (fetch) begin
        out_valid_next = 1'b1;
      end else if (pop) begin
        out_valid_next = 1'b0;
      end
    end

    level_next = ram_cnt_next + level_t'(out_valid_next);
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      ram_cnt_reg   <= '0;
      out_valid_reg <= 1'b0;
      level_reg     <= '0;
      run_reg       <= 1'b0;
      full_reg      <= 1'b0;
      empty_reg     <= 1'b1;
      afull_reg     <= 1'b0;
      aempty_reg    <= 1'b1;
    end else begin
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      ram_cnt_reg   <= ram_cnt_next;
      out_valid_reg <= out_valid_next;
      level_reg     <= level_next;
      run_reg       <= 1'b1;
      // Flags come from the next level so they line up with level.
      full_reg      <= (level_next == level_t'(LEVEL_MAX));
      empty_reg     <= (level_next == '0);
      afull_reg     <= (level_next >= level_t'(AFULL_TH));
      aempty_reg    <= (level_next <= level_t'(AEMPTY_TH));
    end
  end

  // A fetch needs ram_cnt>0 and a push needs ram_cnt<128, so read and
  // write addresses never collide in the same cycle.
  dpram_128x8 memory_fifo (
    .clk      (clk),
    .wen      (push),
    .waddr    (wptr_reg),
    .data_in  (in_data),
    .ren      (fetch),
    .raddr    (rptr_reg),
    .data_out (out_data)
  );

  assign out_valid    = out_valid_reg;
  assign level        = level_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = afull_reg;
  assign almost_empty = aempty_reg;

endmodule

// File: tb/tb_fifo_128x8_ctrl.sv
// tb_fifo_128x8_ctrl
//   Directed and randomized bench for fifo_128x8_ctrl. The reference is a
//   plain queue of accepted entries: level is pushes minus pops, the head
//   shown on out_data must be the oldest entry, and the flags follow level.
module tb_fifo_128x8_ctrl;

  logic       clk = 1'b0;
  logic       RN;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready;
  logic [7:0] level;
  logic       full, empty, almost_full, almost_empty;

  fifo_128x8_ctrl #(.AFULL_TH(120), .AEMPTY_TH(8)) dut (
    .clk          (clk),
    .RN           (RN),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty)
  );

  always #5 clk = ~clk;

  logic [7:0] q[$];
  int checks = 0;
  int passed = 0;
  int stall  = 0;
  int pushes_total = 0;
  logic last_push;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) begin
      passed = passed + 1;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("level", {24'd0, level}, q.size());
    chk("empty", {31'd0, empty}, {31'd0, q.size() == 0});
    chk("full", {31'd0, full}, {31'd0, q.size() == 129});
    chk("almost_full", {31'd0, almost_full}, {31'd0, q.size() >= 120});
    chk("almost_empty", {31'd0, almost_empty}, {31'd0, q.size() <= 8});
  endtask

  // One clock cycle starting at posedge+1: drive, check pre-edge outputs,
  // advance, update the model, check post-edge outputs.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl);
    logic push_m, pop_m;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    #1;
    if (fl) chk("in_ready_flush", {31'd0, in_ready}, 32'd0);
    else if (q.size() < 128) chk("in_ready_room", {31'd0, in_ready}, 32'd1);
    else if (q.size() == 129) chk("in_ready_full", {31'd0, in_ready}, 32'd0);
    push_m = iv & in_ready;
    pop_m  = out_valid & ordy;
    if (out_valid) begin
      chk("valid_nonempty", {31'd0, q.size() > 0}, 32'd1);
      if (q.size() > 0) chk("head_data", {24'd0, out_data}, {24'd0, q[0]});
    end
    @(posedge clk);
    #1;
    if (fl) begin
      q.delete();
    end else begin
      if (pop_m && q.size() > 0) void'(q.pop_front());
      if (push_m) begin
        q.push_back(d);
        pushes_total = pushes_total + 1;
      end
    end
    last_push = push_m & ~fl;
    check_outputs();
    if (q.size() > 0 && !out_valid) stall = stall + 1;
    else stall = 0;
    chk("head_latency", {31'd0, stall <= 2}, 32'd1);
    $display("step iv=%0b d=%02h ordy=%0b fl=%0b push=%0b pop=%0b level=%0d", iv, d, ordy, fl, push_m, pop_m, level);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained", {24'd0, level}, 32'd0);
  endtask

  initial begin
    logic [7:0] d;
    int target;
    RN = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state
    check_outputs();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk) RN = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);

    // Test 1: first-word latency
    step(1'b1, 8'h11, 1'b0, 1'b0);
    chk("t1_valid_e1", {31'd0, out_valid}, 32'd0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    chk("t1_valid_e2", {31'd0, out_valid}, 32'd1);
    chk("t1_data", {24'd0, out_data}, 32'h11);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    chk("t1_level3", {24'd0, level}, 32'd3);
    drain();

    // Test 2: fill to 129 with values 0..128
    d = 8'd0;
    for (int i = 0; i < 300 && q.size() < 129; i++) begin
      step(1'b1, d, 1'b0, 1'b0);
      if (last_push) d = d + 8'd1;
    end
    chk("t2_level129", {24'd0, level}, 32'd129);
    chk("t2_full", {31'd0, full}, 32'd1);
    chk("t2_in_ready", {31'd0, in_ready}, 32'd0);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t2_130th_refused", {24'd0, level}, 32'd129);

    // Test 3: streaming from full
    for (int i = 0; i < 200; i++) begin
      chk("t3_no_gap", {31'd0, out_valid}, 32'd1);
      step(1'b1, d, 1'b1, 1'b0);
      if (last_push) d = d + 8'd1;
      chk("t3_level_range", {31'd0, (level >= 8'd128) && (level <= 8'd129)}, 32'd1);
    end
    drain();

    // Test 4: random traffic, 300 pushes so the pointers wrap twice
    target = pushes_total + 300;
    for (int i = 0; i < 5000 && pushes_total < target; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    chk("t4_pushes_done", {31'd0, pushes_total >= target}, 32'd1);
    drain();

    // Test 5: flush at level 50
    for (int i = 0; i < 200 && q.size() < 50; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
    chk("t5_level50", {24'd0, level}, 32'd50);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("t5_flush_level", {24'd0, level}, 32'd0);
    chk("t5_flush_empty", {31'd0, empty}, 32'd1);
    chk("t5_flush_valid", {31'd0, out_valid}, 32'd0);
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_a5_valid", {31'd0, out_valid}, 32'd1);
    chk("t5_a5_data", {24'd0, out_data}, 32'hA5);
    drain();

    // Test 6: asynchronous reset between edges mid-stream
    for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;
    #2 RN = 1'b0;
    #1;
    chk("t6_level", {24'd0, level}, 32'd0);
    chk("t6_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_empty", {31'd0, empty}, 32'd1);
    chk("t6_in_ready", {31'd0, in_ready}, 32'd0);
    q.delete();
    stall = 0;
    @(negedge clk) RN = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_ready_after", {31'd0, in_ready}, 32'd1);
    check_outputs();
    step(1'b1, 8'h5A, 1'b0, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    chk("t6_head", {24'd0, out_data}, 32'h5A);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
